// File: rtl/core_mem_requester.sv
// rtl/core_mem_requester.sv - per-core load/store requester for the shared RAM arbiter
module core_mem_requester #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int HOLD_CYCLES = 3,
    parameter int TIMEOUT     = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_busy,
    output logic              cpu_done,
    output logic              cpu_err,
    output logic              mem_rden,
    output logic              mem_wren,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic              mem_acq,
    input  logic [DATA_W-1:0] mem_dq
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        HOLD    = 3'd2,
        CAPTURE = 3'd3,
        RELEASE = 3'd4
    } state_t;

    localparam logic [3:0] HOLD_LIM = 4'(HOLD_CYCLES);
    localparam logic [7:0] TMO_LIM  = 8'(TIMEOUT);

    state_t            state_q, state_d;
    logic              op_wr_q, op_wr_d;
    logic [3:0]        hold_q, hold_d;
    logic [7:0]        tmo_q, tmo_d;
    logic [3:0]        hold_inc;
    logic [7:0]        tmo_inc;
    logic [DATA_W-1:0] rdata_d, din_d;
    logic [ADDR_W-1:0] addr_d;
    logic              rden_d, wren_d, done_d, err_d, busy_d;

    // Saturating increments: counters park at all-ones rather than wrapping.
    assign hold_inc = (hold_q == 4'hF) ? hold_q : hold_q + 4'd1;
    assign tmo_inc  = (tmo_q == 8'hFF) ? tmo_q : tmo_q + 8'd1;

    // State register and registered outputs; reset drops any request on this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            op_wr_q   <= 1'b0;
            hold_q    <= 4'd0;
            tmo_q     <= 8'd0;
            cpu_rdata <= '0;
            cpu_busy  <= 1'b0;
            cpu_done  <= 1'b0;
            cpu_err   <= 1'b0;
            mem_rden  <= 1'b0;
            mem_wren  <= 1'b0;
            mem_addr  <= '0;
            mem_din   <= '0;
        end else begin
            state_q   <= state_d;
            op_wr_q   <= op_wr_d;
            hold_q    <= hold_d;
            tmo_q     <= tmo_d;
            cpu_rdata <= rdata_d;
            cpu_busy  <= busy_d;
            cpu_done  <= done_d;
            cpu_err   <= err_d;
            mem_rden  <= rden_d;
            mem_wren  <= wren_d;
            mem_addr  <= addr_d;
            mem_din   <= din_d;
        end
    end

    // Next-state and next-output logic; done/err default low so they pulse for one cycle.
    always_comb begin
        state_d = state_q;
        op_wr_d = op_wr_q;
        hold_d  = hold_q;
        tmo_d   = tmo_q;
        rdata_d = cpu_rdata;
        rden_d  = mem_rden;
        wren_d  = mem_wren;
        addr_d  = mem_addr;
        din_d   = mem_din;
        done_d  = 1'b0;
        err_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                hold_d = 4'd0;
                tmo_d  = 8'd0;
                if (cpu_wr || cpu_rd) begin
                    addr_d  = cpu_addr;
                    din_d   = cpu_wdata;
                    op_wr_d = cpu_wr;
                    wren_d  = cpu_wr;
                    rden_d  = !cpu_wr;
                    state_d = REQ;
                end
            end
            REQ: begin
                tmo_d = tmo_inc;
                if (mem_acq) begin
                    // The granting REQ cycle already counts as the first held cycle.
                    hold_d = 4'd1;
                    if (HOLD_LIM <= 4'd1) begin
                        rden_d  = 1'b0;
                        wren_d  = 1'b0;
                        state_d = CAPTURE;
                    end else begin
                        state_d = HOLD;
                    end
                end else if (tmo_inc >= TMO_LIM) begin
                    rden_d  = 1'b0;
                    wren_d  = 1'b0;
                    err_d   = 1'b1;
                    state_d = RELEASE;
                end
            end
            HOLD: begin
                if (!mem_acq) begin
                    // Grant lost: start over, but the grant-wait budget keeps accumulating.
                    hold_d  = 4'd0;
                    state_d = REQ;
                end else begin
                    hold_d = hold_inc;
                    if (hold_inc >= HOLD_LIM) begin
                        rden_d  = 1'b0;
                        wren_d  = 1'b0;
                        state_d = CAPTURE;
                    end
                end
            end
            CAPTURE: begin
                if (!op_wr_q) begin
                    rdata_d = mem_dq;
                end
                done_d  = 1'b1;
                state_d = RELEASE;
            end
            RELEASE: begin
                // A grant still high here belongs to the finished access, not a new one.
                if (!mem_acq) begin
                    state_d = IDLE;
                end
            end
            default: begin
                rden_d  = 1'b0;
                wren_d  = 1'b0;
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_core_mem_requester.sv
// tb/tb_core_mem_requester.sv - scoreboard bench for core_mem_requester
module tb_core_mem_requester;

    localparam int HOLD = 3;
    localparam int TMO  = 8;
    localparam int NPAT = 64;

    logic       clk, rst;
    logic       cpu_rd, cpu_wr;
    logic [7:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic       cpu_busy, cpu_done, cpu_err;
    logic       mem_rden, mem_wren;
    logic [7:0] mem_addr, mem_din, mem_dq;
    logic       mem_acq;

    core_mem_requester #(
        .ADDR_W(8), .DATA_W(8), .HOLD_CYCLES(HOLD), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_busy(cpu_busy), .cpu_done(cpu_done), .cpu_err(cpu_err),
        .mem_rden(mem_rden), .mem_wren(mem_wren), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_acq(mem_acq), .mem_dq(mem_dq)
    );

    typedef struct {
        bit         is_err;
        logic [7:0] rdata;
        int         cyc;
    } exp_t;

    exp_t       exp_q[$];
    int         vectors = 0;
    int         miscompares = 0;
    int         cyc = 0;
    bit         pat[NPAT];
    logic [7:0] last_rdata = 8'h00;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: walk the grant pattern seen from the first request cycle. Every cycle
    // spent waiting (no unbroken grant run in progress) uses one unit of the TIMEOUT
    // budget; the access succeeds on the HOLD-th consecutive granted cycle and aborts
    // on a grant-less waiting cycle once the budget is spent.
    function automatic void model(output bit is_err, output int kend);
        int run  = 0;
        int reqc = 0;
        is_err = 1'b0;
        kend   = 0;
        for (int k = 0; k < 1000; k++) begin
            bit a;
            a = (k < NPAT) ? pat[k] : 1'b0;
            if (run == 0) begin
                reqc++;
                if (a) begin
                    run = 1;
                    if (run >= HOLD) begin kend = k; return; end
                end else if (reqc >= TMO) begin
                    is_err = 1'b1; kend = k; return;
                end
            end else if (a) begin
                run++;
                if (run >= HOLD) begin kend = k; return; end
            end else begin
                run = 0;
            end
        end
    endfunction

    // Monitor: every done/err pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && (cpu_done || cpu_err)) begin
            if (cpu_done && cpu_err) begin
                chk("done_err_exclusive", 32'(cpu_done & cpu_err), 32'd0);
            end else if (exp_q.size() == 0) begin
                chk("unexpected_pulse", 32'({cpu_done, cpu_err}), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("pulse_kind_err", 32'(cpu_err), 32'(e.is_err));
                chk("pulse_cycle", 32'(cyc), 32'(e.cyc));
                chk("rdata", 32'(cpu_rdata), 32'(e.rdata));
            end
        end
    end

    task automatic wait_idle();
        int guard = 0;
        while (cpu_busy && guard < 300) begin
            mem_acq = 1'b0;
            @(posedge clk); #1;
            guard++;
        end
        if (cpu_busy) chk("idle_timeout", 32'(cpu_busy), 32'd0);
    endtask

    task automatic clear_pat();
        for (int k = 0; k < NPAT; k++) pat[k] = 1'b0;
    endtask

    task automatic run_txn(input bit rd, input bit wr, input logic [7:0] a,
                           input logic [7:0] wd, input logic [7:0] dq, input bit poke);
        bit   is_err;
        bit   exp_wr;
        int   kend, bad, k, guard;
        exp_t e;
        wait_idle();
        exp_wr    = wr;
        cpu_rd    = rd;
        cpu_wr    = wr;
        cpu_addr  = a;
        cpu_wdata = wd;
        mem_dq    = dq;
        mem_acq   = 1'b0;
        model(is_err, kend);
        if (!is_err && !exp_wr) last_rdata = dq;
        e.is_err = is_err;
        e.rdata  = last_rdata;
        e.cyc    = cyc + (is_err ? 2 : 3) + kend;
        exp_q.push_back(e);
        @(posedge clk); #1;
        bad = 0;
        for (k = 0; k <= kend + 1; k++) begin
            mem_acq = (k < NPAT) ? pat[k] : 1'b0;
            if (k == 0) begin
                cpu_rd = poke; cpu_wr = poke & $urandom_range(0, 1);
                cpu_addr = ~a; cpu_wdata = ~wd;
            end else begin
                cpu_rd = 1'b0; cpu_wr = 1'b0;
            end
            if (k <= kend) begin
                if (mem_rden !== !exp_wr || mem_wren !== exp_wr ||
                    mem_addr !== a || mem_din !== wd || cpu_busy !== 1'b1) bad++;
            end else begin
                chk("req_dropped", 32'({mem_rden, mem_wren}), 32'd0);
            end
            @(posedge clk); #1;
        end
        chk("req_window_bad_cycles", 32'(bad), 32'd0);
        guard = 0;
        while (cpu_busy && guard < 200) begin
            mem_acq = (k < NPAT && k <= kend + 4) ? pat[k] : 1'b0;
            k++;
            guard++;
            @(posedge clk); #1;
        end
        mem_acq = 1'b0;
        chk("busy_released", 32'(cpu_busy), 32'd0);
        mem_dq = 8'($urandom);
    endtask

    initial begin
        bit rd, wr;
        rst = 1'b1; cpu_rd = 0; cpu_wr = 0; cpu_addr = 0; cpu_wdata = 0;
        mem_acq = 0; mem_dq = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_outputs",
            32'({cpu_rdata, cpu_busy, cpu_done, cpu_err, mem_rden, mem_wren, mem_addr, mem_din}), 32'd0);

        // Read 0x12, grant two cycles after rden, grant lingers into release.
        clear_pat(); for (int k = 2; k < 7; k++) pat[k] = 1'b1;
        run_txn(1, 0, 8'h12, 8'h00, 8'hA5, 0);
        // Write 0x40/0x3C.
        clear_pat(); for (int k = 1; k < 4; k++) pat[k] = 1'b1;
        run_txn(0, 1, 8'h40, 8'h3C, 8'hEE, 0);
        // Grant loss: two granted, one lost, then a fresh run.
        clear_pat(); pat[1] = 1; pat[2] = 1; for (int k = 4; k < 8; k++) pat[k] = 1'b1;
        run_txn(1, 0, 8'h21, 8'h00, 8'h5A, 0);
        // Timeout with no grant at all.
        clear_pat();
        run_txn(1, 0, 8'h33, 8'h00, 8'h99, 0);
        // Both commands high: write wins; a command poked while busy is ignored.
        clear_pat(); for (int k = 0; k < 3; k++) pat[k] = 1'b1;
        run_txn(1, 1, 8'h44, 8'h77, 8'h11, 1);

        // Reset during HOLD: request drops on the same edge, no pulse follows.
        wait_idle();
        cpu_rd = 1'b1; cpu_addr = 8'h66; mem_acq = 1'b1;
        @(posedge clk); #1;
        cpu_rd = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; mem_acq = 1'b0;
        chk("reset_in_hold",
            32'({cpu_rdata, cpu_busy, cpu_done, cpu_err, mem_rden, mem_wren, mem_addr, mem_din}), 32'd0);
        last_rdata = 8'h00;
        clear_pat(); for (int k = 1; k < 5; k++) pat[k] = 1'b1;
        run_txn(1, 0, 8'h55, 8'h00, 8'hC3, 0);

        // Randomized commands and grant patterns.
        for (int t = 0; t < 40; t++) begin
            int mode, d;
            mode = $urandom_range(0, 3);
            d    = $urandom_range(0, 9);
            for (int k = 0; k < NPAT; k++)
                pat[k] = (mode != 0) && (k >= d) && ($urandom_range(0, 4) != 0);
            rd = $urandom_range(0, 1);
            wr = $urandom_range(0, 1);
            if (!rd && !wr) rd = 1'b1;
            run_txn(rd, wr, 8'($urandom), 8'($urandom), 8'($urandom), $urandom_range(0, 1) == 1);
        end

        wait_idle();
        repeat (3) @(posedge clk);
        #1;
        chk("outstanding_expectations", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
